fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 14 +
 rtl/fetch_pc.sv | 26 ++
 rtl/fetch_unit.sv | 86 ++++++++
 tb/tb_fetch_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared processor definitions used by the fetch stage: FSM state encoding
// and default halt/bubble encodings.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      FETCH    = 2'd0,
      HLT_WAIT = 2'd1,
      HALTED   = 2'd2
   } fetch_state_e;

   localparam logic [3:0]  HLT_OPCODE = 4'hF;
   localparam logic [15:0] NOP_INSTR  = 16'h0000;

endpackage

// File: rtl/fetch_pc.sv
// Program counter register with its next-PC selection.
// Priority: load (redirect) > hold > increment; increment wraps at 16'hFFFF.
module fetch_pc #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        hold,
   input  logic [15:0] target,
   output logic [15:0] pc,
   output logic [15:0] pc_plus1
);

   assign pc_plus1 = pc + 16'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pc <= RESET_PC;
      else if (load)
         pc <= target;
      else if (!hold)
         pc <= pc_plus1;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, IF/ID pipeline register and the
// halt sequencing FSM (FETCH -> HLT_WAIT -> HALTED, HALTED left only by reset).
module fetch_unit #(
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter logic [3:0]  HLT_OPCODE = fetch_unit_pkg::HLT_OPCODE,
   parameter logic [15:0] NOP_INSTR  = fetch_unit_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   input  logic        hlt_retired,
   input  logic [15:0] instr_in,
   output logic [15:0] im_addr,
   output logic        im_rd_en,
   output logic [15:0] if_id_instr,
   output logic [15:0] if_id_pc_plus1,
   output logic        if_id_valid,
   output logic        halted,
   output logic [15:0] fetch_cnt
);

   import fetch_unit_pkg::*;

   fetch_state_e state;
   logic [15:0]  pc_plus1;
   logic         take_redirect;
   logic         is_hlt;
   logic         pc_hold;

   assign take_redirect = redirect && (state != HALTED);
   assign is_hlt        = (instr_in[15:12] == HLT_OPCODE);
   // PC only advances on a non-halt fetch; the halt itself parks the PC.
   assign pc_hold       = stall || (state != FETCH) || is_hlt;

   fetch_pc #(.RESET_PC(RESET_PC)) u_fetch_pc (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (take_redirect),
      .hold     (pc_hold),
      .target   (redirect_pc),
      .pc       (im_addr),
      .pc_plus1 (pc_plus1)
   );

   assign im_rd_en = (state == FETCH);
   assign halted   = (state == HALTED);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= FETCH;
         if_id_instr    <= NOP_INSTR;
         if_id_pc_plus1 <= '0;
         if_id_valid    <= 1'b0;
         fetch_cnt      <= '0;
      end else if (take_redirect) begin
         state       <= FETCH;
         if_id_instr <= NOP_INSTR;
         if_id_valid <= 1'b0;
      end else if (!stall) begin
         case (state)
            FETCH: begin
               if_id_instr    <= instr_in;
               if_id_pc_plus1 <= pc_plus1;
               if_id_valid    <= 1'b1;
               if (fetch_cnt != '1)
                  fetch_cnt <= fetch_cnt + 16'd1;
               if (is_hlt)
                  state <= HLT_WAIT;
            end
            HLT_WAIT: begin
               if_id_instr <= NOP_INSTR;
               if_id_valid <= 1'b0;
               if (hlt_retired)
                  state <= HALTED;
            end
            default: begin
               if_id_instr <= NOP_INSTR;
               if_id_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall, redirect, halt
// sequencing, reset behaviour and PC wrap, against hand-computed values.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        hlt_retired;
   logic [15:0] instr_in;
   logic [15:0] im_addr;
   logic        im_rd_en;
   logic [15:0] if_id_instr;
   logic [15:0] if_id_pc_plus1;
   logic        if_id_valid;
   logic        halted;
   logic [15:0] fetch_cnt;

   logic [15:0] mem [0:255];
   int          vectors = 0;
   int          fails   = 0;

   fetch_unit #(
      .RESET_PC   (16'h0000),
      .HLT_OPCODE (4'hF),
      .NOP_INSTR  (16'h0000)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .hlt_retired    (hlt_retired),
      .instr_in       (instr_in),
      .im_addr        (im_addr),
      .im_rd_en       (im_rd_en),
      .if_id_instr    (if_id_instr),
      .if_id_pc_plus1 (if_id_pc_plus1),
      .if_id_valid    (if_id_valid),
      .halted         (halted),
      .fetch_cnt      (fetch_cnt)
   );

   always #5 clk = ~clk;

   // Memory latches the address on clock low.
   always @(negedge clk) instr_in = mem[im_addr[7:0]];

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, vectors=%0d miscompares=%0d", vectors, fails);
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      vectors++;
      if (im_addr !== 16'h0000) begin fails++; $display("FAIL reset_pc: got %h want 0000", im_addr); end
      vectors++;
      if (im_rd_en !== 1'b1) begin fails++; $display("FAIL reset_rd_en: got %b want 1", im_rd_en); end
      vectors++;
      if ({if_id_valid, halted} !== 2'b00) begin fails++; $display("FAIL reset_valid_halted: got %b want 00", {if_id_valid, halted}); end
      vectors++;
      if ({if_id_instr, if_id_pc_plus1, fetch_cnt} !== 48'h0) begin
         fails++; $display("FAIL reset_regs: got %h %h %h want all 0", if_id_instr, if_id_pc_plus1, fetch_cnt);
      end
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_sequential();
      for (int k = 1; k <= 4; k++) begin
         step();
         vectors++;
         if (im_addr !== 16'(k)) begin fails++; $display("FAIL seq_addr[%0d]: got %h want %h", k, im_addr, 16'(k)); end
         vectors++;
         if (if_id_instr !== 16'h1000 + 16'(k - 1)) begin
            fails++; $display("FAIL seq_instr[%0d]: got %h want %h", k, if_id_instr, 16'h1000 + 16'(k - 1));
         end
         vectors++;
         if ({if_id_valid, if_id_pc_plus1, fetch_cnt} !== {1'b1, 16'(k), 16'(k)}) begin
            fails++; $display("FAIL seq_pc1_cnt[%0d]: got %b %h %h want 1 %h %h", k, if_id_valid, if_id_pc_plus1, fetch_cnt, 16'(k), 16'(k));
         end
      end
   endtask

   task automatic test_stall();
      step();
      stall = 1'b1;
      for (int k = 0; k < 2; k++) begin
         step();
         vectors++;
         if ({im_addr, if_id_instr, fetch_cnt} !== {16'h0005, 16'h1004, 16'h0005}) begin
            fails++; $display("FAIL stall_hold[%0d]: got %h %h %h want 0005 1004 0005", k, im_addr, if_id_instr, fetch_cnt);
         end
      end
      stall = 1'b0;
      step();
      vectors++;
      if ({im_addr, if_id_instr, if_id_pc_plus1, fetch_cnt} !== {16'h0006, 16'h1005, 16'h0006, 16'h0006}) begin
         fails++; $display("FAIL stall_resume: got %h %h %h %h want 0006 1005 0006 0006", im_addr, if_id_instr, if_id_pc_plus1, fetch_cnt);
      end
   endtask

   task automatic test_redirect_stall();
      stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0040;
      step();
      stall = 1'b0; redirect = 1'b0;
      vectors++;
      if ({im_addr, if_id_instr, if_id_valid, fetch_cnt} !== {16'h0040, 16'h0000, 1'b0, 16'h0006}) begin
         fails++; $display("FAIL redir_stall: got %h %h %b %h want 0040 0000 0 0006", im_addr, if_id_instr, if_id_valid, fetch_cnt);
      end
      step();
      vectors++;
      if ({im_addr, if_id_instr, if_id_valid, fetch_cnt} !== {16'h0041, 16'h1040, 1'b1, 16'h0007}) begin
         fails++; $display("FAIL redir_fetch: got %h %h %b %h want 0041 1040 1 0007", im_addr, if_id_instr, if_id_valid, fetch_cnt);
      end
   endtask

   task automatic test_halt();
      redirect = 1'b1; redirect_pc = 16'h0008;
      step();
      redirect = 1'b0;
      step();
      vectors++;
      if ({if_id_instr, if_id_valid, im_addr, im_rd_en, fetch_cnt} !== {16'hF000, 1'b1, 16'h0008, 1'b0, 16'h0008}) begin
         fails++; $display("FAIL halt_fetch: got %h %b %h %b %h want f000 1 0008 0 0008", if_id_instr, if_id_valid, im_addr, im_rd_en, fetch_cnt);
      end
      step();
      vectors++;
      if ({if_id_instr, if_id_valid, im_addr, im_rd_en, halted, fetch_cnt} !== {16'h0000, 1'b0, 16'h0008, 1'b0, 1'b0, 16'h0008}) begin
         fails++; $display("FAIL halt_bubble: got %h %b %h %b %b %h want 0000 0 0008 0 0 0008", if_id_instr, if_id_valid, im_addr, im_rd_en, halted, fetch_cnt);
      end
      hlt_retired = 1'b1;
      step();
      hlt_retired = 1'b0;
      vectors++;
      if ({halted, im_rd_en, if_id_valid} !== 3'b100) begin fails++; $display("FAIL halt_enter: got %b want 100", {halted, im_rd_en, if_id_valid}); end
      redirect = 1'b1; redirect_pc = 16'h0030;
      step();
      step();
      redirect = 1'b0;
      vectors++;
      if ({halted, im_addr} !== {1'b1, 16'h0008}) begin fails++; $display("FAIL halt_sticky: got %b %h want 1 0008", halted, im_addr); end
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({halted, im_addr, fetch_cnt, im_rd_en} !== {1'b0, 16'h0000, 16'h0000, 1'b1}) begin
         fails++; $display("FAIL halt_reset: got %b %h %h %b want 0 0000 0000 1", halted, im_addr, fetch_cnt, im_rd_en);
      end
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_halt_redirect();
      redirect = 1'b1; redirect_pc = 16'h0008;
      step();
      redirect = 1'b0;
      step();
      redirect = 1'b1; hlt_retired = 1'b1; redirect_pc = 16'h0020;
      step();
      redirect = 1'b0; hlt_retired = 1'b0;
      vectors++;
      if ({halted, im_addr, im_rd_en, if_id_valid} !== {1'b0, 16'h0020, 1'b1, 1'b0}) begin
         fails++; $display("FAIL hltwait_redirect: got %b %h %b %b want 0 0020 1 0", halted, im_addr, im_rd_en, if_id_valid);
      end
      step();
      vectors++;
      if ({im_addr, if_id_instr, if_id_valid, fetch_cnt} !== {16'h0021, 16'h1020, 1'b1, 16'h0002}) begin
         fails++; $display("FAIL hltwait_resume: got %h %h %b %h want 0021 1020 1 0002", im_addr, if_id_instr, if_id_valid, fetch_cnt);
      end
   endtask

   task automatic test_wrap();
      redirect = 1'b1; redirect_pc = 16'hFFFF;
      step();
      redirect = 1'b0;
      step();
      vectors++;
      if ({im_addr, if_id_pc_plus1, if_id_instr, if_id_valid} !== {16'h0000, 16'h0000, 16'h10FF, 1'b1}) begin
         fails++; $display("FAIL pc_wrap: got %h %h %h %b want 0000 0000 10ff 1", im_addr, if_id_pc_plus1, if_id_instr, if_id_valid);
      end
   endtask

   task automatic test_reset_midstall();
      stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0077;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({im_addr, fetch_cnt, if_id_valid} !== {16'h0000, 16'h0000, 1'b0}) begin
         fails++; $display("FAIL reset_midstall: got %h %h %b want 0000 0000 0", im_addr, fetch_cnt, if_id_valid);
      end
      step();
      stall = 1'b0; redirect = 1'b0;
      rst_n = 1'b1;
      step();
      vectors++;
      if ({im_addr, if_id_instr, fetch_cnt} !== {16'h0001, 16'h1000, 16'h0001}) begin
         fails++; $display("FAIL reset_no_pending: got %h %h %h want 0001 1000 0001", im_addr, if_id_instr, fetch_cnt);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
      mem[8] = 16'hF000;
      rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; hlt_retired = 1'b0;
      instr_in = '0;
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_stall();
      test_halt();
      test_halt_redirect();
      test_wrap();
      test_reset_midstall();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
